sdu_loader: RTL and testbench

SDU_LOADER -- requirements
Module: sdu_loader

---
 rtl/sdu_loader_if.sv | 23 ++
 rtl/sdu_loader.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_sdu_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdu_loader_if.sv
// -----------------------------------------------------------------------------
// sdu_loader_if
// Byte-stream link between a serial front end (UART or similar) and the
// sdu_loader debug command engine.
//   rx_data  [7:0]  command/operand byte, valid only while rx_valid=1
//   rx_valid        one-cycle strobe per received byte (no back-pressure)
//   tx_data  [7:0]  reply byte
//   tx_valid        reply byte pending; holds until accepted
//   tx_ready        sink accepts; transfer when tx_valid & tx_ready
// master = host/serial side, slave = loader side.
// -----------------------------------------------------------------------------
interface sdu_loader_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output rx_data, output rx_valid, output tx_ready,
                   input  tx_data, input  tx_valid);
   modport slave  (input  rx_data, input  rx_valid, input  tx_ready,
                   output tx_data, output tx_valid);
endinterface

// File: rtl/sdu_loader.sv
// -----------------------------------------------------------------------------
// sdu_loader
// Byte-command debug loader. It decodes commands arriving on the byte link,
// writes instruction/data memory words, reads back CPU state, and controls
// halt / single-step / run of the CPU clock enable.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   link (slave)              rx byte strobe in, tx byte with valid/ready out
//   debug                     1 while CPU halted and debug port owns memories
//   cpu_clk_en                CPU clock enable
//   addr[31:0], din[31:0]     debug word address {16'b0,A} and write data
//   we_im, we_dm              instruction / data memory write strobes
//   dout_im, dout_dm,
//   dout_rf, pc [31:0]        readback sources selected by the 'R' command
// Commands (big-endian operands):
//   'I' A_hi A_lo D3..D0 / 'D' ...  write word, reply 06
//   'R' sel A_hi A_lo                reply 4 data bytes, or 15 if sel>3
//   'S' single step, 'G' run, 'H' halt, reply 06; unknown -> 15
// -----------------------------------------------------------------------------
module sdu_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic          clk,
   input  logic          rstn,
   sdu_loader_if.slave   link,
   output logic          debug,
   output logic          cpu_clk_en,
   output logic [31:0]   addr,
   output logic [31:0]   din,
   output logic          we_im,
   output logic          we_dm,
   input  logic [31:0]   dout_im,
   input  logic [31:0]   dout_dm,
   input  logic [31:0]   dout_rf,
   input  logic [31:0]   pc
);

   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [7:0] OP_I = 8'h49;
   localparam logic [7:0] OP_D = 8'h44;
   localparam logic [7:0] OP_R = 8'h52;
   localparam logic [7:0] OP_S = 8'h53;
   localparam logic [7:0] OP_G = 8'h47;
   localparam logic [7:0] OP_H = 8'h48;
   localparam logic [7:0] ACK  = 8'h06;
   localparam logic [7:0] NAK  = 8'h15;

   typedef enum logic [3:0] {
      IDLE, GET_SEL, GET_AH, GET_AL, GET_DATA, WRITE, READ, LATCH, TX, REPLY
   } state_t;

   state_t           state_reg, state_next;
   logic [7:0]       op_reg, op_next;
   logic [7:0]       sel_reg, sel_next;
   logic [15:0]      a_reg, a_next;          // address assembly shifter
   logic [23:0]      data_reg, data_next;    // D3..D1 assembly shifter
   logic [15:0]      addr_reg, addr_next;
   logic [31:0]      din_reg, din_next;
   logic [31:0]      rdata_reg, rdata_next;
   logic [1:0]       byte_cnt_reg, byte_cnt_next;
   logic [TMO_W-1:0] tmo_reg, tmo_next;
   logic             run_reg, run_next;
   logic             step_reg, step_next;
   logic [7:0]       tx_data_reg, tx_data_next;
   logic             tx_valid_reg, tx_valid_next;

   logic [31:0]      rd_src;
   logic [1:0]       tx_idx;
   logic             in_get;

   always_comb begin
      rd_src = dout_im;
      case (sel_reg[1:0])
         2'd0:    rd_src = dout_im;
         2'd1:    rd_src = dout_dm;
         2'd2:    rd_src = dout_rf;
         default: rd_src = pc;
      endcase
   end

   assign in_get = (state_reg == GET_SEL) || (state_reg == GET_AH) ||
                   (state_reg == GET_AL)  || (state_reg == GET_DATA);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg    <= IDLE;
         op_reg       <= '0;
         sel_reg      <= '0;
         a_reg        <= '0;
         data_reg     <= '0;
         addr_reg     <= '0;
         din_reg      <= '0;
         rdata_reg    <= '0;
         byte_cnt_reg <= '0;
         tmo_reg      <= '0;
         run_reg      <= 1'b0;
         step_reg     <= 1'b0;
         tx_data_reg  <= '0;
         tx_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         op_reg       <= op_next;
         sel_reg      <= sel_next;
         a_reg        <= a_next;
         data_reg     <= data_next;
         addr_reg     <= addr_next;
         din_reg      <= din_next;
         rdata_reg    <= rdata_next;
         byte_cnt_reg <= byte_cnt_next;
         tmo_reg      <= tmo_next;
         run_reg      <= run_next;
         step_reg     <= step_next;
         tx_data_reg  <= tx_data_next;
         tx_valid_reg <= tx_valid_next;
      end
   end

   // --------------------------------------------------------- next state logic
   always_comb begin
      state_next    = state_reg;
      op_next       = op_reg;
      sel_next      = sel_reg;
      a_next        = a_reg;
      data_next     = data_reg;
      addr_next     = addr_reg;
      din_next      = din_reg;
      rdata_next    = rdata_reg;
      byte_cnt_next = byte_cnt_reg;
      run_next      = run_reg;
      step_next     = 1'b0;                 // step enable lasts one cycle
      tx_data_next  = tx_data_reg;
      tx_valid_next = tx_valid_reg;
      tx_idx        = byte_cnt_reg + 2'd1;
      // inter-byte timer only runs while a command is being collected
      tmo_next      = in_get ? (tmo_reg + TMO_W'(1)) : '0;

      case (state_reg)
         IDLE: begin
            if (link.rx_valid) begin
               state_next    = REPLY;
               tx_valid_next = 1'b1;
               tx_data_next  = NAK;
               if (run_reg) begin
                  // only 'H' is honoured while the CPU runs
                  if (link.rx_data == OP_H) begin
                     run_next     = 1'b0;
                     tx_data_next = ACK;
                  end
               end else begin
                  case (link.rx_data)
                     OP_I, OP_D: begin
                        op_next       = link.rx_data;
                        state_next    = GET_AH;
                        tx_valid_next = 1'b0;
                     end
                     OP_R: begin
                        op_next       = link.rx_data;
                        state_next    = GET_SEL;
                        tx_valid_next = 1'b0;
                     end
                     OP_S: begin
                        step_next    = 1'b1;
                        tx_data_next = ACK;
                     end
                     OP_G: begin
                        run_next     = 1'b1;
                        tx_data_next = ACK;
                     end
                     OP_H:    tx_data_next = ACK;
                     default: tx_data_next = NAK;
                  endcase
               end
            end
         end

         GET_SEL, GET_AH, GET_AL, GET_DATA: begin
            if (link.rx_valid) begin
               tmo_next = '0;
               case (state_reg)
                  GET_SEL: begin
                     sel_next   = link.rx_data;
                     state_next = GET_AH;
                  end
                  GET_AH: begin
                     a_next     = {a_reg[7:0], link.rx_data};
                     state_next = GET_AL;
                  end
                  GET_AL: begin
                     a_next = {a_reg[7:0], link.rx_data};
                     if (op_reg == OP_R) begin
                        if (sel_reg > 8'd3) begin
                           state_next    = REPLY;
                           tx_valid_next = 1'b1;
                           tx_data_next  = NAK;
                        end else begin
                           addr_next  = {a_reg[7:0], link.rx_data};
                           state_next = READ;
                        end
                     end else begin
                        byte_cnt_next = 2'd0;
                        state_next    = GET_DATA;
                     end
                  end
                  default: begin  // GET_DATA
                     data_next = {data_reg[15:0], link.rx_data};
                     if (byte_cnt_reg == 2'd3) begin
                        addr_next  = a_reg;
                        din_next   = {data_reg, link.rx_data};
                        state_next = WRITE;
                     end else begin
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                     end
                  end
               endcase
            end else if (tmo_reg == TMO_LAST) begin
               // silent abort: no write, no reply
               state_next = IDLE;
               tmo_next   = '0;
            end
         end

         WRITE: begin
            state_next    = REPLY;
            tx_valid_next = 1'b1;
            tx_data_next  = ACK;
         end

         // addr presented for one cycle so a registered-read memory can respond
         READ: state_next = LATCH;

         LATCH: begin
            rdata_next    = rd_src;
            tx_data_next  = rd_src[31:24];
            tx_valid_next = 1'b1;
            byte_cnt_next = 2'd0;
            state_next    = TX;
         end

         TX: begin
            if (tx_valid_reg && link.tx_ready) begin
               if (byte_cnt_reg == 2'd3) begin
                  tx_valid_next = 1'b0;
                  state_next    = IDLE;
               end else begin
                  byte_cnt_next = tx_idx;
                  case (tx_idx)
                     2'd1:    tx_data_next = rdata_reg[23:16];
                     2'd2:    tx_data_next = rdata_reg[15:8];
                     default: tx_data_next = rdata_reg[7:0];
                  endcase
               end
            end
         end

         REPLY: begin
            if (tx_valid_reg && link.tx_ready) begin
               tx_valid_next = 1'b0;
               state_next    = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   assign cpu_clk_en    = run_reg | step_reg;
   assign debug         = ~(run_reg | step_reg);
   // strobes are additionally gated by debug so a write can never hit a running CPU
   assign we_im         = (state_reg == WRITE) && (op_reg == OP_I) && debug;
   assign we_dm         = (state_reg == WRITE) && (op_reg == OP_D) && debug;
   assign addr          = {16'h0000, addr_reg};
   assign din           = din_reg;
   assign link.tx_data  = tx_data_reg;
   assign link.tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_sdu_loader.sv
// -----------------------------------------------------------------------------
// tb_sdu_loader
// Directed bench for sdu_loader: write, read (with and without back-pressure),
// run/halt/step, inter-byte timeout, bad opcodes/sel, dropped bytes, reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdu_loader;

   localparam int TMO = 20;

   logic        clk;
   logic        rstn;
   logic        debug, cpu_clk_en, we_im, we_dm;
   logic [31:0] addr, din;
   logic [31:0] dout_im, dout_dm, dout_rf, pc;

   sdu_loader_if bus ();

   sdu_loader #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .link       (bus.slave),
      .debug      (debug),
      .cpu_clk_en (cpu_clk_en),
      .addr       (addr),
      .din        (din),
      .we_im      (we_im),
      .we_dm      (we_dm),
      .dout_im    (dout_im),
      .dout_dm    (dout_dm),
      .dout_rf    (dout_rf),
      .pc         (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // transfer / strobe observers (sampled on the edge, pre-update values)
   logic [7:0]  txq[$];
   int          tx_cyc[$];
   int          cyc = 0;
   int          we_im_cnt = 0;
   int          we_dm_cnt = 0;
   int          en_cnt = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_din = '0;

   always @(posedge clk) begin
      cyc++;
      if (bus.tx_valid && bus.tx_ready) begin
         txq.push_back(bus.tx_data);
         tx_cyc.push_back(cyc);
         $display("[%0t] tx byte %02h", $time, bus.tx_data);
      end
      if (we_im) begin
         we_im_cnt++;
         wr_addr = addr;
         wr_din  = din;
      end
      if (we_dm) we_dm_cnt++;
      if (cpu_clk_en) en_cnt++;
   end

   task automatic step_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   task automatic wait_tx(input int n);
      int i;
      i = 0;
      while (txq.size() < n && i < 300) begin
         @(posedge clk);
         #1;
         i++;
      end
   endtask

   task automatic clear_obs();
      txq.delete();
      tx_cyc.delete();
      we_im_cnt = 0;
      we_dm_cnt = 0;
      en_cnt    = 0;
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      rstn = 1'b0;
      step_cyc(3);
      checks++; if (debug !== 1'b1) begin errors++; $display("FAIL reset_debug got %b exp 1", debug); end
      checks++; if (cpu_clk_en !== 1'b0) begin errors++; $display("FAIL reset_clk_en got %b exp 0", cpu_clk_en); end
      checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", bus.tx_valid); end
      checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %02h exp 00", bus.tx_data); end
      checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %08h exp 0", addr); end
      checks++; if (din !== 32'h0) begin errors++; $display("FAIL reset_din got %08h exp 0", din); end
      checks++; if ({we_im, we_dm} !== 2'b00) begin errors++; $display("FAIL reset_we got %b exp 00", {we_im, we_dm}); end
      rstn = 1'b1;
      step_cyc(2);
      $display("test_reset done");
   endtask

   task automatic test_write_im();
      clear_obs();
      send_byte(8'h49); send_byte(8'h00); send_byte(8'h05);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      wait_tx(1);
      step_cyc(3);
      checks++; if (we_im_cnt !== 1) begin errors++; $display("FAIL wr_we_im_cycles got %0d exp 1", we_im_cnt); end
      checks++; if (we_dm_cnt !== 0) begin errors++; $display("FAIL wr_we_dm_cycles got %0d exp 0", we_dm_cnt); end
      checks++; if (wr_addr !== 32'h0000_0005) begin errors++; $display("FAIL wr_addr got %08h exp 00000005", wr_addr); end
      checks++; if (wr_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_din got %08h exp deadbeef", wr_din); end
      checks++; if (txq.size() !== 1 || txq[0] !== 8'h06) begin errors++; $display("FAIL wr_reply got n=%0d b=%02h exp n=1 b=06", txq.size(), (txq.size() > 0) ? txq[0] : 8'hxx); end
      checks++; if (addr !== 32'h5 || din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_hold got %08h/%08h exp 00000005/deadbeef", addr, din); end
      $display("test_write_im done");
   endtask

   task automatic test_read();
      logic [7:0] exp_b [4];
      exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      clear_obs();
      dout_im = 32'hDEAD_BEEF;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
      wait_tx(4);
      checks++; if (txq.size() !== 4) begin errors++; $display("FAIL rd_count got %0d exp 4", txq.size()); end
      if (txq.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (txq[i] !== exp_b[i]) begin errors++; $display("FAIL rd_byte%0d got %02h exp %02h", i, txq[i], exp_b[i]); end
         end
         checks++; if (tx_cyc[3] - tx_cyc[0] !== 3) begin errors++; $display("FAIL rd_consecutive got span %0d exp 3", tx_cyc[3] - tx_cyc[0]); end
      end
      checks++; if (addr !== 32'h5) begin errors++; $display("FAIL rd_addr got %08h exp 00000005", addr); end
      $display("test_read done");
   endtask

   task automatic test_read_pc();
      logic [7:0] exp_b [4];
      exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
      clear_obs();
      pc = 32'h1234_5678;
      send_byte(8'h52); send_byte(8'h03); send_byte(8'h00); send_byte(8'h09);
      wait_tx(4);
      checks++; if (txq.size() !== 4) begin errors++; $display("FAIL rdpc_count got %0d exp 4", txq.size()); end
      if (txq.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (txq[i] !== exp_b[i]) begin errors++; $display("FAIL rdpc_byte%0d got %02h exp %02h", i, txq[i], exp_b[i]); end
         end
      end
      checks++; if (addr !== 32'h9) begin errors++; $display("FAIL rdpc_addr got %08h exp 00000009", addr); end
      $display("test_read_pc done");
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_b [4];
      int  i;
      bit  stable;
      exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      clear_obs();
      bus.tx_ready = 1'b0;
      send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
      i = 0;
      while (!bus.tx_valid && i < 20) begin step_cyc(1); i++; end
      checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hDE) begin errors++; $display("FAIL bp_first got v=%b d=%02h exp v=1 d=de", bus.tx_valid, bus.tx_data); end
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step_cyc(1);
         if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hDE) stable = 1'b0;
      end
      checks++; if (stable !== 1'b1 || txq.size() !== 0) begin errors++; $display("FAIL bp_hold got stable=%b n=%0d exp stable=1 n=0", stable, txq.size()); end
      bus.tx_ready = 1'b1;
      wait_tx(4);
      checks++; if (txq.size() !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", txq.size()); end
      if (txq.size() >= 4) begin
         for (int j = 0; j < 4; j++) begin
            checks++; if (txq[j] !== exp_b[j]) begin errors++; $display("FAIL bp_byte%0d got %02h exp %02h", j, txq[j], exp_b[j]); end
         end
      end
      $display("test_backpressure done");
   endtask

   task automatic test_run_mode();
      clear_obs();
      send_byte(8'h47);
      wait_tx(1);
      checks++; if (cpu_clk_en !== 1'b1 || debug !== 1'b0) begin errors++; $display("FAIL run_on got en=%b dbg=%b exp en=1 dbg=0", cpu_clk_en, debug); end
      send_byte(8'h44);
      wait_tx(2);
      checks++; if (cpu_clk_en !== 1'b1) begin errors++; $display("FAIL run_before_h got en=%b exp 1", cpu_clk_en); end
      send_byte(8'h48);
      checks++; if (cpu_clk_en !== 1'b0 || debug !== 1'b1) begin errors++; $display("FAIL run_halt got en=%b dbg=%b exp en=0 dbg=1", cpu_clk_en, debug); end
      wait_tx(3);
      step_cyc(2);
      checks++; if (txq.size() !== 3 || txq[0] !== 8'h06 || txq[1] !== 8'h15 || txq[2] !== 8'h06) begin
         errors++; $display("FAIL run_replies got n=%0d exp 06 15 06", txq.size()); end
      checks++; if (we_dm_cnt !== 0 || we_im_cnt !== 0) begin errors++; $display("FAIL run_no_write got dm=%0d im=%0d exp 0", we_dm_cnt, we_im_cnt); end
      $display("test_run_mode done");
   endtask

   task automatic test_step();
      clear_obs();
      send_byte(8'h53);
      wait_tx(1);
      step_cyc(3);
      checks++; if (en_cnt !== 1) begin errors++; $display("FAIL step_pulse got %0d cycles exp 1", en_cnt); end
      checks++; if (txq.size() !== 1 || txq[0] !== 8'h06) begin errors++; $display("FAIL step_reply got n=%0d exp one 06", txq.size()); end
      checks++; if (debug !== 1'b1) begin errors++; $display("FAIL step_debug got %b exp 1", debug); end
      $display("test_step done");
   endtask

   task automatic test_timeout();
      clear_obs();
      send_byte(8'h44); send_byte(8'h00);
      step_cyc(TMO + 10);
      checks++; if (txq.size() !== 0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL tmo_silent got n=%0d v=%b exp 0/0", txq.size(), bus.tx_valid); end
      checks++; if (we_dm_cnt !== 0) begin errors++; $display("FAIL tmo_no_write got %0d exp 0", we_dm_cnt); end
      send_byte(8'h53);
      wait_tx(1);
      step_cyc(2);
      checks++; if (en_cnt !== 1) begin errors++; $display("FAIL tmo_step_pulse got %0d exp 1", en_cnt); end
      checks++; if (txq.size() !== 1 || txq[0] !== 8'h06) begin errors++; $display("FAIL tmo_step_reply got n=%0d exp one 06", txq.size()); end
      $display("test_timeout done");
   endtask

   task automatic test_bad();
      clear_obs();
      send_byte(8'h7A);
      wait_tx(1);
      checks++; if (txq.size() !== 1 || txq[0] !== 8'h15) begin errors++; $display("FAIL bad_opcode got n=%0d exp one 15", txq.size()); end
      clear_obs();
      send_byte(8'h52); send_byte(8'h07); send_byte(8'h00); send_byte(8'h00);
      wait_tx(1);
      step_cyc(6);
      checks++; if (txq.size() !== 1 || txq[0] !== 8'h15) begin errors++; $display("FAIL bad_sel got n=%0d exp one 15", txq.size()); end
      $display("test_bad done");
   endtask

   task automatic test_drop();
      clear_obs();
      bus.tx_ready = 1'b0;
      send_byte(8'h48);
      send_byte(8'h7A);     // arrives while the 06 reply is pending
      step_cyc(2);
      bus.tx_ready = 1'b1;
      step_cyc(10);
      checks++; if (txq.size() !== 1 || txq[0] !== 8'h06) begin errors++; $display("FAIL drop_in_reply got n=%0d exp one 06", txq.size()); end
      $display("test_drop done");
   endtask

   task automatic test_reset_mid_reply();
      clear_obs();
      bus.tx_ready = 1'b0;
      send_byte(8'h47);
      step_cyc(3);
      checks++; if (bus.tx_valid !== 1'b1 || debug !== 1'b0) begin errors++; $display("FAIL rst_setup got v=%b dbg=%b exp v=1 dbg=0", bus.tx_valid, debug); end
      #2 rstn = 1'b0;
      #1;
      checks++; if (bus.tx_valid !== 1'b0 || debug !== 1'b1 || cpu_clk_en !== 1'b0) begin
         errors++; $display("FAIL rst_async got v=%b dbg=%b en=%b exp 0/1/0", bus.tx_valid, debug, cpu_clk_en); end
      checks++; if (addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %08h exp 0", addr); end
      @(posedge clk);
      #1;
      rstn = 1'b1;
      bus.tx_ready = 1'b1;
      step_cyc(5);
      checks++; if (txq.size() !== 0) begin errors++; $display("FAIL rst_discard got n=%0d exp 0", txq.size()); end
      $display("test_reset_mid_reply done");
   endtask

   initial begin
      rstn         = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.tx_ready = 1'b1;
      dout_im      = 32'h0;
      dout_dm      = 32'hA5A5_0001;
      dout_rf      = 32'h5A5A_0002;
      pc           = 32'h0;

      test_reset();
      test_write_im();
      test_read();
      test_read_pc();
      test_backpressure();
      test_run_mode();
      test_step();
      test_timeout();
      test_bad();
      test_drop();
      test_reset_mid_reply();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
